// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: 4 slide switches -> 8 LEDs (static/chase/bounce/count).
// Ports: clk, reset (sync, high), s[3:0] raw switches, led[7:0], tick; opt LED_PWM_DIM_EN.
module led_pattern_sequencer #(
  parameter int TICK_DIV   = 12_500_000,
  parameter int DEB_CYCLES = 500_000,
  parameter int PWM_BITS   = 4,
  parameter int DIM_DUTY   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s,
  output logic [7:0] led,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] TMAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    M_STATIC = 2'b00,
    M_CHASE  = 2'b01,
    M_BOUNCE = 2'b10,
    M_COUNT  = 2'b11
  } mode_t;

  logic [3:0]    s_meta;
  logic [3:0]    s_sync;
  logic [3:0]    s_db;
  logic [DW-1:0] db_cnt [4];

  mode_t         mode_q;
  mode_t         mode_d;
  mode_t         mode;
  logic          pause;
  logic          dir;
  logic [7:0]    pattern;
  logic [7:0]    pattern_d;
  logic          bdir;
  logic          bdir_d;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_d;
  logic          step;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_meta <= '0;
      s_sync <= '0;
      s_db   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      s_meta <= s;
      s_sync <= s_meta;
      for (int i = 0; i < 4; i++) begin
        if (s_sync[i] == s_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DMAX) begin
          db_cnt[i] <= '0;
          s_db[i]   <= s_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign mode  = mode_t'(s_db[1:0]);
  assign pause = s_db[2];
  assign dir   = s_db[3];
  assign tick  = (presc == TMAX);
  assign step  = tick & ~pause;

  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern;
    bdir_d    = bdir;
    presc_d   = tick ? '0 : presc + 1'b1;
    if (mode != mode_q) begin
      // entry wins over a coincident tick
      mode_d  = mode;
      presc_d = '0;
      unique case (mode)
        M_CHASE:  pattern_d = dir ? 8'h80 : 8'h01;
        M_BOUNCE: begin
          pattern_d = dir ? 8'h80 : 8'h01;
          bdir_d    = dir;
        end
        M_COUNT:  pattern_d = 8'h00;
        default:  pattern_d = {~s_db, s_db};
      endcase
    end else if (mode_q == M_STATIC) begin
      pattern_d = {~s_db, s_db};
    end else if (step) begin
      unique case (mode_q)
        M_CHASE: begin
          if (dir) pattern_d = {pattern[0], pattern[7:1]};
          else     pattern_d = {pattern[6:0], pattern[7]};
        end
        M_BOUNCE: begin
          if (!bdir) begin
            if (pattern[7]) begin
              pattern_d = 8'h40;
              bdir_d    = 1'b1;
            end else begin
              pattern_d = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              pattern_d = 8'h02;
              bdir_d    = 1'b0;
            end else begin
              pattern_d = pattern >> 1;
            end
          end
        end
        M_COUNT: begin
          if (dir) pattern_d = pattern - 8'd1;
          else     pattern_d = pattern + 8'd1;
        end
        default: pattern_d = pattern;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= M_STATIC;
      pattern <= 8'h00;
      bdir    <= 1'b0;
      presc   <= '0;
    end else begin
      mode_q  <= mode_d;
      pattern <= pattern_d;
      bdir    <= bdir_d;
      presc   <= presc_d;
    end
  end

`ifdef LED_PWM_DIM_EN
  localparam logic [PWM_BITS:0] DUTY = (PWM_BITS+1)'(DIM_DUTY);
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      led     <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= pattern & {8{({1'b0, pwm_cnt} < DUTY)}};
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) led <= 8'h00;
    else       led <= pattern;
  end
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized bench for led_pattern_sequencer against a behavioural model.
// TICK_DIV=4, DEB_CYCLES=3; checks led and tick every cycle.
module tb_led_pattern_sequencer;

  localparam int TD  = 4;
  localparam int DB  = 3;
  localparam int PB  = 4;
  localparam int DTY = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s;
  logic [7:0] led;
  logic       tick;

  led_pattern_sequencer #(
    .TICK_DIV(TD), .DEB_CYCLES(DB),
    .PWM_BITS(PB), .DIM_DUTY(DTY)
  ) dut (
    .clk(clk), .reset(reset), .s(s),
    .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  int m_s1, m_s2, m_db, m_mode, m_pat, m_down, m_pre, m_led, m_pwm;
  int m_cnt [4];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
  endtask

  function automatic int init_pat(int md, int db);
    case (md)
      1, 2:    return ((db >> 3) & 1) ? 128 : 1;
      3:       return 0;
      default: return ((~db & 15) << 4) | db;
    endcase
  endfunction

  task automatic model_edge(input int rst, input int sw);
    int db, md, pz, dr, tk, ndb, p;
    if (rst != 0) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_mode = 0; m_pat = 0;
      m_down = 0; m_pre = 0; m_led = 0; m_pwm = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      return;
    end
    db = m_db;
    md = db % 4;
    pz = (db / 4) % 2;
    dr = (db / 8) % 2;
    tk = (m_pre == TD - 1);
`ifdef LED_PWM_DIM_EN
    m_led = (m_pwm < DTY) ? m_pat : 0;
    m_pwm = (m_pwm + 1) % (1 << PB);
`else
    m_led = m_pat;
`endif
    p = m_pat;
    if (md != m_mode) begin
      m_mode = md;
      m_pre = 0;
      p = init_pat(md, db);
      if (md == 2) m_down = dr;
    end else begin
      m_pre = (m_pre + 1) % TD;
      if (md == 0) p = init_pat(0, db);
      else if (tk && !pz) begin
        if (md == 1) p = dr ? ((p >> 1) | ((p & 1) << 7)) : (((p << 1) | (p >> 7)) & 255);
        else if (md == 3) p = dr ? (p + 255) % 256 : (p + 1) % 256;
        else begin
          if (!m_down && p == 128) m_down = 1;
          else if (m_down && p == 1) m_down = 0;
          p = m_down ? p / 2 : p * 2;
        end
      end
    end
    m_pat = p;
    ndb = db;
    for (int i = 0; i < 4; i++) begin
      if (((m_s2 >> i) & 1) != ((db >> i) & 1)) begin
        m_cnt[i]++;
        if (m_cnt[i] == DB) begin
          m_cnt[i] = 0;
          ndb = ndb ^ (1 << i);
        end
      end else m_cnt[i] = 0;
    end
    m_db = ndb;
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(int'(reset), int'(s));
    #1;
    chk("led", led, 8'(m_led));
    chk("tick", {7'd0, tick}, 8'(m_pre == TD - 1));
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    s = v;
    repeat (n) cyc();
  endtask

  initial begin
    logic [3:0] v;
    int r;
    reset = 1'b1;
    s = 4'h0;
    repeat (2) cyc();
    reset = 1'b0;
    hold(4'h0, 12);
    hold(4'h1, 2);
    hold(4'h0, 8);
    hold(4'h1, 40);
    hold(4'h9, 20);
    hold(4'hA, 60);
    hold(4'hB, 20);
    hold(4'hF, 16);
    hold(4'hB, 20);
    hold(4'h3, 30);
    v = 4'h3;
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        s = v ^ 4'($urandom_range(1, 15));
        repeat ($urandom_range(1, 2)) cyc();
        hold(v, $urandom_range(1, 6));
      end else if (r == 1) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 2)) cyc();
        reset = 1'b0;
      end else begin
        v = 4'($urandom_range(0, 15));
        hold(v, $urandom_range(3, 40));
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
